// File: rtl/grant_collector_pkg.sv
// Shared types and defaults for the grant FIFO collector.
// Lane count, entry layout and the lowest-grant decode helper.
package grant_collector_pkg;

    localparam int NUM_LANES     = 4;
    localparam int DEFAULT_DW    = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef logic [1:0] src_idx_t;

    typedef struct packed {
        src_idx_t                src;
        logic [DEFAULT_DW-1:0]   data;
    } entry_t;

    // Multi-hot grants resolve to the lowest set bit.
    function automatic src_idx_t lowest_idx(
        input logic [NUM_LANES-1:0] g
    );
        src_idx_t idx;
        idx = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (g[k]) idx = src_idx_t'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: registered storage, wrapping pointers, occupancy.
// A push while full is accepted only when a pop frees the head slot.
module sync_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] cnt;
    logic          wr;
    logic          rd;

    assign full  = (cnt == LW'(DEPTH));
    assign empty = (cnt == '0);
    assign wr    = push && (!full || pop);
    assign rd    = pop && !empty;
    assign dout  = mem[rptr];
    assign level = cnt;

    // Storage write at the tail; cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr) begin
            mem[wptr] <= din;
        end
    end

    // Pointer advance (modulo DEPTH by width) and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            case ({wr, rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/grant_fifo_collector.sv
// Collects granted requester beats into a FIFO, tagged with lane index.
// GRANT_DROP_CNT_EN builds a saturating count of beats dropped when full.
module grant_fifo_collector
    import grant_collector_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             gnt,
    input  logic [DW-1:0]          din0,
    input  logic [DW-1:0]          din1,
    input  logic [DW-1:0]          din2,
    input  logic [DW-1:0]          din3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [1:0]             out_src,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic [7:0]             drop_cnt
);

    localparam int EW = 2 + DW;

    src_idx_t      sel;
    logic [DW-1:0] lane;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign sel       = lowest_idx(gnt);
    assign push      = |gnt;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    // Lane mux driven by the decoded grant index.
    always_comb begin
        lane = din0;
        case (sel)
            2'd1:    lane = din1;
            2'd2:    lane = din2;
            2'd3:    lane = din3;
            default: lane = din0;
        endcase
    end

    sync_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({sel, lane}),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign out_src  = head[EW-1 -: 2];
    assign out_data = head[DW-1:0];

`ifdef GRANT_DROP_CNT_EN
    logic drop;
    assign drop = push && full && !pop;

    // Saturating count of pushes lost to a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 8'd255) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: doc/grant_fifo_collector.md
GRANT_FIFO_COLLECTOR -- requirements
Module: grant_fifo_collector

Interface
REQ-001 SHALL have parameter DW, default 8: data width of each requester lane.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 gnt  input  4  one-hot grant from the upstream round-robin arbiter; bit i selects lane i.
REQ-007 din0..din3  input  DW each  requester data lanes 0..3.
REQ-008 out_valid  output  1  FIFO head holds a beat.
REQ-009 out_ready  input  1  consumer accepts the head beat.
REQ-010 out_data  output  DW  head beat data.
REQ-011 out_src  output  2  lane index of the head beat.
REQ-012 level  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 full  output  1  level == DEPTH.
REQ-014 empty  output  1  level == 0.
REQ-015 drop_cnt  output  8  count of beats dropped while the FIFO is full.

Function
REQ-016 Each cycle with gnt != 0 SHALL be one push request; gnt == 0 SHALL push nothing.
REQ-017 A push SHALL store {index of gnt, din[index]}; a grant held N cycles SHALL push N beats.
REQ-018 A multi-hot gnt SHALL select the lowest set bit.
REQ-019 A pop SHALL occur when out_valid && out_ready.
REQ-020 out_valid SHALL equal !empty; out_data and out_src SHALL come directly from the head entry (registered storage, no combinational path from din).
REQ-021 A beat pushed at edge N SHALL be visible at the outputs after edge N, so first availability is 1 cycle after the grant.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 Occupancy SHALL change by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-024 Push while full with no pop SHALL be dropped: storage is unchanged and drop_cnt increments.
REQ-025 Push while full together with a pop SHALL be accepted; level stays DEPTH.
REQ-026 Pop while empty SHALL be impossible, since out_valid is 0.
REQ-027 Push while empty together with out_ready = 1 SHALL store the beat; it is not bypassed.
REQ-028 Beats SHALL leave in strict arrival order.

Reset
REQ-029 rst asserted SHALL immediately clear pointers, level, drop_cnt and all storage to 0; this gives out_valid = 0, out_data = 0, out_src = 0, empty = 1, full = 0.
REQ-030 Reset mid-operation SHALL discard all stored beats, with no partial push or pop.
REQ-031 The first push SHALL be possible at the first clock edge after rst deasserts.

Configuration
REQ-032 Macro GRANT_DROP_CNT_EN SHALL gate the drop counter.
REQ-033 When GRANT_DROP_CNT_EN is defined, drop_cnt SHALL be an 8-bit counter that saturates at 255.
REQ-034 When GRANT_DROP_CNT_EN is undefined, drop_cnt SHALL be tied to 0 and no counter logic is built; all other behaviour is identical.

Structure
REQ-035 Package grant_collector_pkg SHALL hold:
- NUM_LANES = 4
- default DW and DEPTH
- typedef src_idx_t (2 bits)
- typedef entry_t {src_idx_t src; data}
REQ-036 Sub-module sync_fifo SHALL implement the storage, pointers and level; the top level holds grant decode, lane mux and the drop counter.

Verification
REQ-037 Reset with no grants: out_valid = 0, empty = 1, level = 0, drop_cnt = 0.
REQ-038 gnt = 0100 for 1 cycle with din2 = 8'hA5 and out_ready = 0: next cycle out_valid = 1, out_data = A5, out_src = 2, level = 1.
REQ-039 gnt cycles 0001, 0010, 0100, 1000 with din = 11, 22, 33, 44 and out_ready = 0: full = 1, level = 4; then out_ready = 1 drains 11/0, 22/1, 33/2, 44/3 on consecutive cycles.
REQ-040 FIFO full, gnt = 0001 for 3 cycles, out_ready = 0: level stays 4, drop_cnt = 3 (0 without GRANT_DROP_CNT_EN), contents unchanged.
REQ-041 FIFO full, gnt = 1000 with out_ready = 1 in the same cycle: level stays 4, the old head pops and the new beat lands at the tail.
REQ-042 rst pulsed mid-burst with level = 3: level = 0 and out_valid = 0 immediately; the next gnt pushes normally.
